// File: rtl/pbs_pkg.sv
// Shared battle constants, move codes and small helpers
// used by the PBS datapath and the battle controller.
package pbs_pkg;

  localparam int DEF_HP_W         = 8;
  localparam int DEF_P_MAX_HP     = 100;
  localparam int DEF_AI_MAX_HP    = 100;
  localparam int DEF_P_ATK        = 12;
  localparam int DEF_AI_ATK       = 10;
  localparam int DEF_HEAL_AMT     = 20;
  localparam int DEF_CATCH_THRESH = 25;

  localparam logic [7:0] DEF_LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    MV_BATTLE = 2'd0,
    MV_HEAL   = 2'd1,
    MV_CATCH  = 2'd2
  } move_e;

  typedef enum logic {
    CATCH_IDLE = 1'b0,
    CATCH_PEND = 1'b1
  } catch_st_e;

  typedef struct packed {
    logic p_dmg;
    logic ai_dmg;
    logic heal;
    logic bad;
  } hit_t;

  // x^8+x^6+x^5+x^4+1, shift left; zero escapes to 1
  function automatic logic [7:0] lfsr_next(
    input logic [7:0] v
  );
    if (v == 8'h00) return 8'h01;
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

endpackage

// File: rtl/pbs_datapath_if.sv
// Command strobes from the battle controller and the
// HP / catch status returned by the datapath.
interface pbs_datapath_if #(
  parameter int HP_W = 8
);

  logic            load_ai_hp;
  logic            apply_p_damage;
  logic            apply_ai_damage;
  logic            active_trainer;
  logic            target;
  logic            p_heal;
  logic            catch_req;

  logic [HP_W-1:0] p_hp;
  logic [HP_W-1:0] ai_hp;
  logic            p_dead;
  logic            ai_dead;
  logic            catch_valid;
  logic            catch_success;
  logic            protocol_err;

  modport master (
    output load_ai_hp,
    output apply_p_damage,
    output apply_ai_damage,
    output active_trainer,
    output target,
    output p_heal,
    output catch_req,
    input  p_hp,
    input  ai_hp,
    input  p_dead,
    input  ai_dead,
    input  catch_valid,
    input  catch_success,
    input  protocol_err
  );

  modport slave (
    input  load_ai_hp,
    input  apply_p_damage,
    input  apply_ai_damage,
    input  active_trainer,
    input  target,
    input  p_heal,
    input  catch_req,
    output p_hp,
    output ai_hp,
    output p_dead,
    output ai_dead,
    output catch_valid,
    output catch_success,
    output protocol_err
  );

endinterface

// File: rtl/pbs_lfsr.sv
// Free-running 8-bit Fibonacci LFSR, reloaded with
// the seed while reset is held.
module pbs_lfsr
  import pbs_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  // advance one step every cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) value <= seed;
    else          value <= lfsr_next(value);
  end

endmodule

// File: rtl/pbs_datapath.sv
// HP registers, damage/heal arithmetic and the catch
// roll for one player-vs-AI Pokemon battle.
module pbs_datapath
  import pbs_pkg::*;
#(
  parameter int         HP_W         = DEF_HP_W,
  parameter int         P_MAX_HP     = DEF_P_MAX_HP,
  parameter int         AI_MAX_HP    = DEF_AI_MAX_HP,
  parameter int         P_ATK        = DEF_P_ATK,
  parameter int         AI_ATK       = DEF_AI_ATK,
  parameter int         HEAL_AMT     = DEF_HEAL_AMT,
  parameter int         CATCH_THRESH = DEF_CATCH_THRESH,
  parameter int         VARIANCE_EN  = 1,
  parameter logic [7:0] LFSR_SEED    = DEF_LFSR_SEED
) (
  input logic           clk,
  input logic           reset_n,
  pbs_datapath_if.slave bus
);

  localparam int DW = HP_W + 1;

  localparam logic [DW-1:0] P_ATK_W  = DW'(P_ATK);
  localparam logic [DW-1:0] AI_ATK_W = DW'(AI_ATK);
  localparam logic [DW-1:0] HEAL_W   = DW'(HEAL_AMT);
  localparam logic [DW-1:0] P_MAX_W  = DW'(P_MAX_HP);

  localparam logic [HP_W-1:0] P_MAX_H  = HP_W'(P_MAX_HP);
  localparam logic [HP_W-1:0] AI_MAX_H = HP_W'(AI_MAX_HP);
  localparam logic [HP_W-1:0] THR_H    = HP_W'(CATCH_THRESH);

  logic [7:0]      lfsr;
  logic            unused_lfsr_hi;
  logic [HP_W-1:0] p_hp_q;
  logic [HP_W-1:0] ai_hp_q;
  logic [HP_W-1:0] p_nxt;
  logic [HP_W-1:0] ai_nxt;
  logic [HP_W-1:0] p_sub;
  logic [HP_W-1:0] ai_sub;
  logic [HP_W-1:0] p_add;
  logic [DW-1:0]   dmg;
  logic [DW-1:0]   bonus;
  logic [DW-1:0]   p_ext;
  logic [DW-1:0]   ai_ext;
  logic [DW-1:0]   p_sum;
  logic            p_dead;
  logic            ai_dead;
  logic            take;
  logic            roll;
  hit_t            hit;
  catch_st_e       cst_q;
  logic            res_q;
  logic            cv_q;
  logic            cs_q;
  logic            perr_q;

  pbs_lfsr u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .seed    (LFSR_SEED),
    .value   (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[7:4];

  assign p_dead  = (p_hp_q == '0);
  assign ai_dead = (ai_hp_q == '0);

  assign bonus = (VARIANCE_EN != 0) ? DW'(lfsr[2:0]) : '0;
  assign dmg   = (bus.active_trainer ? AI_ATK_W : P_ATK_W) + bonus;

  assign p_ext  = {1'b0, p_hp_q};
  assign ai_ext = {1'b0, ai_hp_q};
  assign p_sub  = (dmg >= p_ext) ? '0 : p_hp_q - dmg[HP_W-1:0];
  assign ai_sub = (dmg >= ai_ext) ? '0 : ai_hp_q - dmg[HP_W-1:0];
  assign p_sum  = p_ext + HEAL_W;
  assign p_add  = (p_sum >= P_MAX_W) ? P_MAX_H : p_sum[HP_W-1:0];

  // classify strobes; any illegal mix blocks the HP update
  always_comb begin
    logic both;
    logic p_dir;
    logic ai_dir;
    both   = bus.apply_p_damage & bus.apply_ai_damage;
    p_dir  = ~bus.target & bus.active_trainer;
    ai_dir = bus.target & ~bus.active_trainer;
    hit.bad    = both
               | (bus.apply_ai_damage & ~ai_dir)
               | (bus.apply_p_damage & ~p_dir)
               | (bus.p_heal & bus.apply_p_damage);
    hit.p_dmg  = bus.apply_p_damage & p_dir & ~both
               & ~bus.p_heal & ~p_dead;
    hit.ai_dmg = bus.apply_ai_damage & ai_dir & ~both
               & ~ai_dead & ~bus.load_ai_hp;
    hit.heal   = bus.p_heal & ~bus.apply_p_damage & ~p_dead;
  end

  // next player HP
  always_comb begin
    p_nxt = p_hp_q;
    unique case (1'b1)
      hit.p_dmg: p_nxt = p_sub;
      hit.heal:  p_nxt = p_add;
      default:   ;
    endcase
  end

  // next AI HP; reload wins over damage
  always_comb begin
    ai_nxt = ai_hp_q;
    unique case (1'b1)
      bus.load_ai_hp: ai_nxt = AI_MAX_H;
      hit.ai_dmg:     ai_nxt = ai_sub;
      default:        ;
    endcase
  end

  assign take = bus.catch_req & ~ai_dead & ~bus.load_ai_hp;
  assign roll = (ai_hp_q <= THR_H) | (lfsr[3:0] == 4'd0);

  // HP registers and sticky protocol error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_hp_q  <= P_MAX_H;
      ai_hp_q <= AI_MAX_H;
      perr_q  <= 1'b0;
    end else begin
      p_hp_q  <= p_nxt;
      ai_hp_q <= ai_nxt;
      if (hit.bad) perr_q <= 1'b1;
    end
  end

  // catch roll latched, reported one edge later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cst_q <= CATCH_IDLE;
      res_q <= 1'b0;
      cv_q  <= 1'b0;
      cs_q  <= 1'b0;
    end else begin
      cv_q <= 1'b0;
      unique case (cst_q)
        CATCH_IDLE: begin
          if (take) begin
            cst_q <= CATCH_PEND;
            res_q <= roll;
          end
        end
        CATCH_PEND: begin
          cst_q <= CATCH_IDLE;
          if (!bus.load_ai_hp) begin
            cv_q <= 1'b1;
            cs_q <= res_q;
          end
        end
        default: cst_q <= CATCH_IDLE;
      endcase
      if (bus.load_ai_hp) cs_q <= 1'b0;
    end
  end

  assign bus.p_hp          = p_hp_q;
  assign bus.ai_hp         = ai_hp_q;
  assign bus.p_dead        = p_dead;
  assign bus.ai_dead       = ai_dead;
  assign bus.catch_valid   = cv_q;
  assign bus.catch_success = cs_q;
  assign bus.protocol_err  = perr_q;

endmodule

// File: doc/pbs_datapath.md
PBS_DATAPATH -- requirements
Module: pbs_datapath

Interface
REQ-001 Parameter HP_W, default 8, HP register width.
REQ-002 Parameter P_MAX_HP, default 100, player Pokemon full HP.
REQ-003 Parameter AI_MAX_HP, default 100, AI Pokemon full HP.
REQ-004 Parameter P_ATK, default 12, player base damage.
REQ-005 Parameter AI_ATK, default 10, AI base damage.
REQ-006 Parameter HEAL_AMT, default 20, HP restored per heal.
REQ-007 Parameter CATCH_THRESH, default 25, AI HP at or below which a catch always succeeds.
REQ-008 Parameter VARIANCE_EN, default 1; when 1, damage gets a random 0..7 bonus.
REQ-009 Parameter LFSR_SEED, default 8'hA5, LFSR value on reset; SHALL be nonzero.
REQ-010 clk  in  1  the single clock; all state updates on its rising edge.
REQ-011 reset_n  in  1  reset, asynchronous, active-low.
REQ-012 load_ai_hp  in  1  pulse: reload AI HP to AI_MAX_HP.
REQ-013 apply_p_damage  in  1  pulse: apply damage to player Pokemon.
REQ-014 apply_ai_damage  in  1  pulse: apply damage to AI Pokemon.
REQ-015 active_trainer  in  1  attacker select; 0 player, 1 AI.
REQ-016 target  in  1  victim select; 0 player Pokemon, 1 AI Pokemon.
REQ-017 p_heal  in  1  pulse: heal player Pokemon by HEAL_AMT.
REQ-018 catch_req  in  1  pulse: attempt catch of AI Pokemon.
REQ-019 p_hp  out  HP_W  player HP.
REQ-020 ai_hp  out  HP_W  AI HP.
REQ-021 p_dead  out  1  high when p_hp == 0.
REQ-022 ai_dead  out  1  high when ai_hp == 0.
REQ-023 catch_valid  out  1  one-cycle pulse: catch result ready.
REQ-024 catch_success  out  1  last catch result, held.
REQ-025 protocol_err  out  1  sticky flag: illegal strobe combination seen.

Function
REQ-026 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, SHALL advance every clock cycle, never reaching 0.
REQ-027 Damage = (active_trainer ? AI_ATK : P_ATK) + (VARIANCE_EN ? lfsr[2:0] : 0), computed in HP_W+1 bits.
REQ-028 apply_ai_damage with target=1 and active_trainer=0 SHALL set ai_hp to max(ai_hp - damage, 0) at that edge.
REQ-029 apply_p_damage with target=0 and active_trainer=1 SHALL set p_hp to max(p_hp - damage, 0) at that edge.
REQ-030 A damage strobe whose target/active_trainer disagree, or both damage strobes in one cycle, SHALL change no HP and SHALL set protocol_err.
REQ-031 p_heal SHALL set p_hp to min(p_hp + HEAL_AMT, P_MAX_HP). When p_dead is high, p_heal SHALL be ignored.
REQ-032 p_heal and apply_p_damage in the same cycle SHALL set protocol_err; neither takes effect.
REQ-033 When a dead flag is high, damage to that Pokemon SHALL be ignored; HP stays 0.
REQ-034 load_ai_hp SHALL load AI_MAX_HP and take priority over any same-cycle AI damage or catch_req. It SHALL clear catch_success.
REQ-035 p_dead and ai_dead SHALL be combinational compares on the HP registers, so they are valid in the cycle after the updating edge.
REQ-036 Catch on a catch_req edge with ai_dead low: result = (ai_hp <= CATCH_THRESH) || (lfsr[3:0] == 0), using that edge's values.
REQ-037 At the next edge after REQ-036, catch_valid SHALL pulse for 1 cycle and catch_success SHALL take the result.
REQ-038 catch_req while ai_dead is high, or while a result is pending, SHALL be ignored and produce no catch_valid.
REQ-039 catch_success SHALL hold until the next catch result or load_ai_hp.
REQ-040 protocol_err SHALL clear only on reset.

Reset
REQ-041 While reset_n is low: p_hp=P_MAX_HP, ai_hp=AI_MAX_HP, lfsr=LFSR_SEED, and catch_valid, catch_success, protocol_err, pending state all 0. This is immediate, independent of clk.
REQ-042 Reset asserted mid-catch SHALL discard the pending result; no catch_valid follows.

Structure
REQ-043 Shared package pbs_pkg SHALL hold the default HP/attack/heal/threshold constants and the MV_BATTLE/MV_HEAL/MV_CATCH move encodings shared with the battle controller.
REQ-044 The LFSR SHALL be a separate sub-module pbs_lfsr (ports clk, reset_n, seed, value).

Verification
REQ-045 VARIANCE_EN=0, after reset, apply_ai_damage with target=1, active_trainer=0 -> ai_hp 100->88, then 76.
REQ-046 VARIANCE_EN=0, nine AI hits on player (active_trainer=1, target=0) -> p_hp 10; tenth hit -> p_hp 0, p_dead=1; eleventh hit -> no change.
REQ-047 p_hp=90, p_heal -> p_hp=100 (saturated). p_hp=50, p_heal -> 70.
REQ-048 ai_hp=28 then P_ATK hit (VARIANCE_EN=0) -> ai_hp=16; catch_req -> catch_valid pulse next cycle with catch_success=1; load_ai_hp -> ai_hp=100, catch_success=0.
REQ-049 apply_ai_damage with target=0 -> HP unchanged, protocol_err=1; protocol_err persists until reset_n pulse.
REQ-050 Assert reset_n low between clock edges during a pending catch -> outputs at reset values immediately, no catch_valid afterward.
